// File: rtl/mmio_hex_monitor.sv
// Captures each change of a 24-bit memory-mapped word into a small FIFO and shows
// queued values one at a time on six active-low seven-segment digits.
module mmio_hex_monitor #(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int DEPTH       = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [23:0]              watch_in,
   output logic [6:0]               hex0,
   output logic [6:0]               hex1,
   output logic [6:0]               hex2,
   output logic [6:0]               hex3,
   output logic [6:0]               hex4,
   output logic [6:0]               hex5,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     busy,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(HOLD_CYCLES) + 1;

   localparam logic [AW:0]   FILL_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   FILL_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   FILL_ZERO  = '0;
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [TW-1:0] TIMER_ZERO = '0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SHOW = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic [23:0]     r_prev;
   logic [23:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_fill;
   logic [TW-1:0]   r_timer;
   logic [23:0]     r_disp;
   logic            r_blank;
   logic            r_overflow;

   logic            w_change;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   // A pop only happens from IDLE, so a full FIFO can accept a change in the pop cycle.
   always_comb begin
      w_change = (watch_in != r_prev);
      w_full   = (r_fill == FILL_FULL);
      w_pop    = (r_state == S_IDLE) && (r_fill != FILL_ZERO);
      w_push   = w_change && (!w_full || w_pop);
      w_drop   = w_change && w_full && !w_pop;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_next_state = S_SHOW;
            end
         end
         S_SHOW: begin
            if (r_timer == TIMER_ZERO) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_prev <= '0;
      end else begin
         r_prev <= watch_in;
      end
   end

   // Storage is not reset; the cleared pointers and fill make old entries unreachable.
   always_ff @(posedge clock) begin
      if (reset_n && w_push) begin
         r_mem[r_wr_ptr] <= watch_in;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + FILL_ONE;
            2'b01:   r_fill <= r_fill - FILL_ONE;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_timer <= '0;
         r_disp  <= '0;
         r_blank <= 1'b1;
      end else if (w_pop) begin
         r_timer <= TIMER_LOAD;
         r_disp  <= r_mem[r_rd_ptr];
         r_blank <= 1'b0;
      end else if ((r_state == S_SHOW) && (r_timer != TIMER_ZERO)) begin
         r_timer <= r_timer - TIMER_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign hex0     = r_blank ? 7'b1111111 : seg7(r_disp[3:0]);
   assign hex1     = r_blank ? 7'b1111111 : seg7(r_disp[7:4]);
   assign hex2     = r_blank ? 7'b1111111 : seg7(r_disp[11:8]);
   assign hex3     = r_blank ? 7'b1111111 : seg7(r_disp[15:12]);
   assign hex4     = r_blank ? 7'b1111111 : seg7(r_disp[19:16]);
   assign hex5     = r_blank ? 7'b1111111 : seg7(r_disp[23:20]);
   assign fill     = r_fill;
   assign busy     = (r_state == S_SHOW);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_mmio_hex_monitor.sv
// Directed bench for mmio_hex_monitor: vector table plus hand sequences for
// full-FIFO pop/push, mid-SHOW reset, steady input and a single-cycle hold instance.
module tb_mmio_hex_monitor;

   logic        clock;
   logic        reset_n;
   logic [23:0] watch_in;
   logic [23:0] watch1;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic [2:0]  fill;
   logic        busy, overflow;
   logic [6:0]  h1_0, h1_1, h1_2, h1_3, h1_4, h1_5;
   logic [1:0]  fill1;
   logic        busy1, overflow1;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        rst_n;
      logic [23:0] w;
      int          fill;
      logic        busy;
      logic        ovf;
      logic        blank;
      logic [23:0] disp;
   } vec_t;

   vec_t tbl[$];

   mmio_hex_monitor #(.HOLD_CYCLES(4), .DEPTH(4)) dut (
      .clock(clock), .reset_n(reset_n), .watch_in(watch_in),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
      .fill(fill), .busy(busy), .overflow(overflow)
   );

   mmio_hex_monitor #(.HOLD_CYCLES(1), .DEPTH(2)) dut1 (
      .clock(clock), .reset_n(reset_n), .watch_in(watch1),
      .hex0(h1_0), .hex1(h1_1), .hex2(h1_2), .hex3(h1_3), .hex4(h1_4), .hex5(h1_5),
      .fill(fill1), .busy(busy1), .overflow(overflow1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g [16];
      g = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return g[n];
   endfunction

   function automatic logic [41:0] exp_hex(input logic blank, input logic [23:0] d);
      if (blank) return '1;
      return {glyph(d[23:20]), glyph(d[19:16]), glyph(d[15:12]),
              glyph(d[11:8]), glyph(d[7:4]), glyph(d[3:0])};
   endfunction

   task automatic chk(input string nm, input int af, input logic ab, input logic ao,
                      input logic [41:0] ah, input int ef, input logic eb, input logic eo,
                      input logic eblank, input logic [23:0] ed);
      logic [41:0] eh;
      eh = exp_hex(eblank, ed);
      n_chk++;
      if (af != ef) begin
         n_err++;
         $display("FAIL %s fill: got %0d want %0d", nm, af, ef);
      end
      n_chk++;
      if (ab !== eb) begin
         n_err++;
         $display("FAIL %s busy: got %b want %b", nm, ab, eb);
      end
      n_chk++;
      if (ao !== eo) begin
         n_err++;
         $display("FAIL %s overflow: got %b want %b", nm, ao, eo);
      end
      n_chk++;
      if (ah !== eh) begin
         n_err++;
         $display("FAIL %s hex5..0: got %h want %h", nm, ah, eh);
      end
   endtask

   task automatic chk0(input string nm, input int ef, input logic eb, input logic eo,
                       input logic eblank, input logic [23:0] ed);
      chk(nm, int'(fill), busy, overflow, {hex5, hex4, hex3, hex2, hex1, hex0},
          ef, eb, eo, eblank, ed);
   endtask

   task automatic chk1(input string nm, input int ef, input logic eb,
                       input logic eblank, input logic [23:0] ed);
      chk(nm, int'(fill1), busy1, overflow1, {h1_5, h1_4, h1_3, h1_2, h1_1, h1_0},
          ef, eb, 1'b0, eblank, ed);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic rn, input logic [23:0] w, input int f, input logic b,
                      input logic o, input logic bl, input logic [23:0] d);
      vec_t v;
      v = '{rst_n: rn, w: w, fill: f, busy: b, ovf: o, blank: bl, disp: d};
      tbl.push_back(v);
   endtask

   initial begin
      reset_n  = 1'b0;
      watch_in = '0;
      watch1   = '0;

      // reset held two cycles, then released with no change
      add(0, 24'h0, 0, 0, 0, 1, 24'h0);
      add(0, 24'h0, 0, 0, 0, 1, 24'h0);
      add(1, 24'h0, 0, 0, 0, 1, 24'h0);
      add(1, 24'h0, 0, 0, 0, 1, 24'h0);
      // single change 0xA5: push, pop next edge, four SHOW cycles
      add(1, 24'hA5, 1, 0, 0, 1, 24'h0);
      for (int i = 0; i < 4; i++) add(1, 24'hA5, 0, 1, 0, 0, 24'hA5);
      add(1, 24'hA5, 0, 0, 0, 0, 24'hA5);
      add(1, 24'hA5, 0, 0, 0, 0, 24'hA5);
      // six back-to-back changes: 1 shown, 2..5 queued, 6 dropped
      add(1, 24'h1, 1, 0, 0, 0, 24'hA5);
      add(1, 24'h2, 1, 1, 0, 0, 24'h1);
      add(1, 24'h3, 2, 1, 0, 0, 24'h1);
      add(1, 24'h4, 3, 1, 0, 0, 24'h1);
      add(1, 24'h5, 4, 1, 0, 0, 24'h1);
      add(1, 24'h6, 4, 0, 1, 0, 24'h1);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) add(1, 24'h6, 3 - k, 1, 1, 0, 24'(k + 2));
         add(1, 24'h6, 3 - k, 0, 1, 0, 24'(k + 2));
      end

      foreach (tbl[i]) begin
         reset_n  = tbl[i].rst_n;
         watch_in = tbl[i].w;
         tick();
         chk0($sformatf("vec%0d", i), tbl[i].fill, tbl[i].busy, tbl[i].ovf,
              tbl[i].blank, tbl[i].disp);
      end

      // full FIFO: a change in the pop cycle is accepted
      reset_n = 1'b0; watch_in = 24'h0; tick();
      chk0("rst_clr_ovf", 0, 0, 0, 1, 24'h0);
      reset_n = 1'b1;
      watch_in = 24'h11; tick(); chk0("fp_push", 1, 0, 0, 1, 24'h0);
      watch_in = 24'h12; tick(); chk0("fp_pop1", 1, 1, 0, 0, 24'h11);
      watch_in = 24'h13; tick();
      watch_in = 24'h14; tick();
      watch_in = 24'h15; tick(); chk0("fp_full", 4, 1, 0, 0, 24'h11);
      tick();                    chk0("fp_idle", 4, 0, 0, 0, 24'h11);
      watch_in = 24'h16; tick(); chk0("fp_pushpop", 4, 1, 0, 0, 24'h12);
      for (int i = 0; i < 5; i++) tick();
      chk0("fp_next", 3, 1, 0, 0, 24'h13);

      // reset mid-SHOW with three queued values and a concurrent change
      reset_n = 1'b0; watch_in = 24'h77; tick();
      chk0("rs_show", 0, 0, 0, 1, 24'h0);
      watch_in = 24'h0; tick();
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk0($sformatf("rs_quiet%0d", i), 0, 0, 0, 1, 24'h0);
      end

      // non-zero input right after reset is a change; steady input afterwards is not
      reset_n = 1'b0; tick();
      reset_n = 1'b1; watch_in = 24'h123456; tick();
      chk0("st_push", 1, 0, 0, 1, 24'h0);
      tick();
      chk0("st_pop", 0, 1, 0, 0, 24'h123456);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk0($sformatf("st_hold%0d", i), 0, (i < 3), 0, 0, 24'h123456);
      end

      // HOLD_CYCLES=1 instance: one SHOW cycle, pop-to-pop spacing of two
      reset_n = 1'b0; tick();
      reset_n = 1'b1;
      watch1 = 24'h1; tick(); chk1("h1_e1", 1, 0, 1, 24'h0);
      watch1 = 24'h2; tick(); chk1("h1_e2", 1, 1, 0, 24'h1);
      watch1 = 24'h3; tick(); chk1("h1_e3", 2, 0, 0, 24'h1);
      tick();                 chk1("h1_e4", 1, 1, 0, 24'h2);
      tick();                 chk1("h1_e5", 1, 0, 0, 24'h2);
      tick();                 chk1("h1_e6", 0, 1, 0, 24'h3);
      tick();                 chk1("h1_e7", 0, 0, 0, 24'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mmio_hex_monitor.md
MMIO_HEX_MONITOR -- requirements
Module: mmio_hex_monitor

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 25_000_000: clock cycles each captured value is held on the display (minimum 1).
REQ-002 The block SHALL have parameter DEPTH, default 4: capture FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 The block SHALL have port watch_in, input, 24: memory-mapped output word from the hart state (RAM bytes 96..98, byte 96 in bits 7:0), sampled every cycle.
REQ-006 The block SHALL have ports hex0..hex5, output, 7 each: active-low seven-segment patterns; hex0 shows display value bits 3:0, hex5 shows bits 23:20.
REQ-007 The block SHALL have port fill, output, $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
REQ-008 The block SHALL have port busy, output, 1: high while in SHOW state.
REQ-009 The block SHALL have port overflow, output, 1: sticky; set when a change is dropped.

Function
REQ-010 Change detection SHALL use register prev, loaded with watch_in every cycle; a change is a cycle in which watch_in != prev.
REQ-011 On a change with FIFO not full, or full with a pop in the same cycle, watch_in SHALL be written to the FIFO tail at that edge.
REQ-012 On a change with FIFO full and no pop in that cycle, the value SHALL be dropped, overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-013 The FIFO SHALL preserve order; pointers SHALL wrap modulo DEPTH; fill SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-014 The FSM SHALL have two states, IDLE and SHOW.
REQ-015 In IDLE with fill>0, the block SHALL pop the head into display register disp, load timer with HOLD_CYCLES-1, and enter SHOW at the same edge.
REQ-016 In IDLE with fill==0, the block SHALL hold disp unchanged.
REQ-017 In SHOW, timer SHALL decrement each cycle; when timer==0, the FSM SHALL return to IDLE, so disp is held for exactly HOLD_CYCLES cycles.
REQ-018 The next pop SHALL occur no earlier than the cycle following the return to IDLE, giving a pop-to-pop spacing of HOLD_CYCLES+1 cycles.
REQ-019 Latency SHALL be as follows: a change present in cycle n is pushed at edge n; if IDLE and the FIFO was empty, it is popped at edge n+1 and visible on hex0..5 after edge n+1.
REQ-020 hex outputs SHALL be combinational from disp and blank, using the standard active-low 0-F glyphs (0=1000000, 1=1111001, ..., F=0001110).
REQ-021 The blank flag SHALL force all hex outputs to 1111111; it is set by reset and cleared at the first pop.
REQ-022 The timer width SHALL be $clog2(HOLD_CYCLES)+1 bits; HOLD_CYCLES=1 SHALL hold disp for a single cycle, with no underflow.

Reset
REQ-023 While reset_n=0 at an edge, the block SHALL set prev=0, clear the FIFO (pointers 0, fill=0), set state=IDLE, timer=0, disp=0, blank=1, and overflow=0.
REQ-024 Reset SHALL override all other activity, including a push or pop in the same cycle.
REQ-025 Reset asserted mid-SHOW SHALL abandon the displayed value and all queued values.
REQ-026 In the first cycle after reset, a non-zero watch_in SHALL count as a change against prev=0.
REQ-027 Outputs after reset SHALL be: hex0..5=1111111, fill=0, busy=0, overflow=0.

Verification (HOLD_CYCLES=4, DEPTH=4)
REQ-028 Test: hold reset_n=0 for 2 cycles with watch_in=0x000000, then release. Expected: all hex outputs 1111111, fill=0, busy=0, overflow=0, and no push.
REQ-029 Test: from idle, set watch_in=0x0000A5 for 1 cycle. Expected: fill 0->1->0; busy high for exactly 4 cycles; hex0=0010010 ('5'), hex1=0001000 ('A'), hex2..5='0'.
REQ-030 Test: change watch_in on 6 consecutive cycles (0x1..0x6). Expected: value 0x1 is popped immediately; 0x2..0x5 queue (fill peaks at 4); 0x6 is dropped and overflow goes 1 and stays 1; display sequence is 1,2,3,4,5 at 5-cycle spacing.
REQ-031 Test: with the FIFO full, change watch_in in the same cycle the FSM pops. Expected: push accepted, fill stays 4, overflow stays 0.
REQ-032 Test: assert reset_n=0 during SHOW with fill=3. Expected: next cycle fill=0, busy=0, hex blank, overflow=0, and no queued value is ever displayed.
REQ-033 Test: hold watch_in at a constant 0x123456 for 20 cycles after it is displayed once. Expected: no further pushes; disp stays 0x123456 and hex5..hex0 show 1,2,3,4,5,6.
